// File: rtl/led_pattern_gen.sv
`timescale 1ns/1ps
// led_pattern_gen
// Multi-channel LED pattern generator. A shared prescaler produces a pattern
// tick. Each channel independently runs OFF, ON, BLINK or BURST with its own
// period and high time (in ticks). Channels are reprogrammed at run time over
// a valid/ready port, and the LED outputs are registered so they can drive
// board pins directly.
module led_pattern_gen #(
    parameter int CLK_HZ  = 50000000,
    parameter int TICK_HZ = 1000,
    parameter int N_CH    = 4,
    parameter int PER_W   = 16,
    parameter int CNT_W   = 8,
    localparam int CH_W   = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic [CH_W-1:0]  cfg_ch,
    input  logic [1:0]       cfg_mode,
    input  logic [PER_W-1:0] cfg_period,
    input  logic [PER_W-1:0] cfg_high,
    input  logic [CNT_W-1:0] cfg_count,
    output logic [N_CH-1:0]  led,
    output logic [N_CH-1:0]  done
);

    localparam int               DIV      = CLK_HZ / TICK_HZ;
    localparam int               PRE_W    = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(DIV - 1);

    typedef enum logic [1:0] {
        MODE_OFF   = 2'b00,
        MODE_ON    = 2'b01,
        MODE_BLINK = 2'b10,
        MODE_BURST = 2'b11
    } mode_e;

    logic [PRE_W-1:0] prescale_q;
    logic [PRE_W-1:0] prescale_d;
    logic             cfgReady_q;
    logic             cfgReady_d;

    mode_e            mode_q   [N_CH];
    mode_e            mode_d   [N_CH];
    logic [PER_W-1:0] period_q [N_CH];
    logic [PER_W-1:0] period_d [N_CH];
    logic [PER_W-1:0] high_q   [N_CH];
    logic [PER_W-1:0] high_d   [N_CH];
    logic [PER_W-1:0] phase_q  [N_CH];
    logic [PER_W-1:0] phase_d  [N_CH];
    logic [CNT_W-1:0] remain_q [N_CH];
    logic [CNT_W-1:0] remain_d [N_CH];

    logic [N_CH-1:0]  led_q;
    logic [N_CH-1:0]  led_d;
    logic [N_CH-1:0]  done_q;
    logic [N_CH-1:0]  done_d;
    logic [N_CH-1:0]  pendDone_q;
    logic [N_CH-1:0]  pendDone_d;

    logic             tick;
    logic             accept;
    logic [PER_W-1:0] lastPhase [N_CH];
    logic [N_CH-1:0]  chSel;
    logic [N_CH-1:0]  running;
    logic [N_CH-1:0]  atWrap;

    // Prescaler and handshake: tick marks the last count of each prescaler
    // period, and ready drops for one cycle after every accepted transfer so
    // that at most one config lands every two cycles.
    always_comb begin
        tick       = (prescale_q == PRE_LAST);
        prescale_d = tick ? '0 : prescale_q + 1'b1;
        accept     = cfg_valid & cfgReady_q;
        cfgReady_d = ~accept;
    end

    // Per-channel decode: which channel a transfer targets (out-of-range
    // channel numbers match nothing), whether the phase counter is running,
    // and whether this tick wraps the phase. A period of 0 behaves as 1.
    always_comb begin
        for (int i = 0; i < N_CH; i++) begin
            chSel[i]     = accept && (int'(cfg_ch) == i);
            lastPhase[i] = (period_q[i] == '0) ? '0 : period_q[i] - 1'b1;
            running[i]   = (mode_q[i] == MODE_BLINK) || (mode_q[i] == MODE_BURST);
            atWrap[i]    = tick && running[i] && (phase_q[i] == lastPhase[i]);
        end
    end

    // Channel next state. A config write to a channel overrides anything its
    // tick would have done on the same edge, so a burst ending on that edge
    // produces no done. A burst that finishes (or is loaded with count 0)
    // goes OFF straight away and raises a pending flag that becomes the done
    // pulse one edge later, lining the pulse up with the LED turning off.
    always_comb begin
        for (int i = 0; i < N_CH; i++) begin
            mode_d[i]     = mode_q[i];
            period_d[i]   = period_q[i];
            high_d[i]     = high_q[i];
            phase_d[i]    = phase_q[i];
            remain_d[i]   = remain_q[i];
            pendDone_d[i] = 1'b0;
            done_d[i]     = pendDone_q[i];

            case (mode_q[i])
                MODE_OFF: led_d[i] = 1'b0;
                MODE_ON:  led_d[i] = 1'b1;
                default:  led_d[i] = (phase_q[i] < high_q[i]);
            endcase

            if (chSel[i]) begin
                period_d[i] = cfg_period;
                high_d[i]   = cfg_high;
                phase_d[i]  = '0;
                remain_d[i] = cfg_count;
                done_d[i]   = 1'b0;
                if ((mode_e'(cfg_mode) == MODE_BURST) && (cfg_count == '0)) begin
                    mode_d[i]     = MODE_OFF;
                    pendDone_d[i] = 1'b1;
                end else begin
                    mode_d[i] = mode_e'(cfg_mode);
                end
            end else if (tick && running[i]) begin
                if (atWrap[i]) begin
                    phase_d[i] = '0;
                    if (mode_q[i] == MODE_BURST) begin
                        if (remain_q[i] <= CNT_W'(1)) begin
                            remain_d[i]   = '0;
                            mode_d[i]     = MODE_OFF;
                            pendDone_d[i] = 1'b1;
                        end else begin
                            remain_d[i] = remain_q[i] - 1'b1;
                        end
                    end
                end else begin
                    phase_d[i] = phase_q[i] + 1'b1;
                end
            end
        end
    end

    // State registers with synchronous reset; reset drops any in-flight
    // config and any pending done.
    always_ff @(posedge clk) begin
        if (rst) begin
            prescale_q <= '0;
            cfgReady_q <= 1'b0;
            led_q      <= '0;
            done_q     <= '0;
            pendDone_q <= '0;
            for (int i = 0; i < N_CH; i++) begin
                mode_q[i]   <= MODE_OFF;
                period_q[i] <= '0;
                high_q[i]   <= '0;
                phase_q[i]  <= '0;
                remain_q[i] <= '0;
            end
        end else begin
            prescale_q <= prescale_d;
            cfgReady_q <= cfgReady_d;
            led_q      <= led_d;
            done_q     <= done_d;
            pendDone_q <= pendDone_d;
            for (int i = 0; i < N_CH; i++) begin
                mode_q[i]   <= mode_d[i];
                period_q[i] <= period_d[i];
                high_q[i]   <= high_d[i];
                phase_q[i]  <= phase_d[i];
                remain_q[i] <= remain_d[i];
            end
        end
    end

    assign cfg_ready = cfgReady_q;
    assign led       = led_q;
    assign done      = done_q;

endmodule

// File: tb/tb_led_pattern_gen.sv
`timescale 1ns/1ps
// tb_led_pattern_gen
// Bench for led_pattern_gen with a 10-clock tick (CLK_HZ=100, TICK_HZ=10).
// Each driven cycle queues its expected outputs; a monitor pops and compares
// them just after the following clock edge. A second 5-channel instance
// checks that an out-of-range channel number is accepted and ignored.
module tb_led_pattern_gen;

    localparam int CLK_HZ  = 100;
    localparam int TICK_HZ = 10;
    localparam int N_CH    = 4;
    localparam int PER_W   = 16;
    localparam int CNT_W   = 8;

    localparam logic [1:0] M_OFF   = 2'b00;
    localparam logic [1:0] M_ON    = 2'b01;
    localparam logic [1:0] M_BLINK = 2'b10;
    localparam logic [1:0] M_BURST = 2'b11;

    typedef struct {
        string            name;
        logic             rst;
        logic             valid;
        logic             valid2;
        logic [2:0]       ch;
        logic [1:0]       mode;
        logic [PER_W-1:0] period;
        logic [PER_W-1:0] high;
        logic [CNT_W-1:0] count;
        logic [3:0]       expLed;
        logic [3:0]       expDone;
        logic             expReady;
        logic             readyCare;
        logic [4:0]       expLed2;
        logic             expReady2;
        logic             dut2Care;
    } vec_t;

    logic             clk;
    logic             rst;
    logic             cfgValid;
    logic             cfgValid2;
    logic [2:0]       cfgCh;
    logic [1:0]       cfgMode;
    logic [PER_W-1:0] cfgPeriod;
    logic [PER_W-1:0] cfgHigh;
    logic [CNT_W-1:0] cfgCount;
    logic             cfgReady;
    logic [3:0]       led;
    logic [3:0]       done;
    logic             cfgReady2;
    logic [4:0]       led2;
    logic [4:0]       done2;

    vec_t sb[$];
    vec_t tbl[$];
    int   nChecks = 0;
    int   nFails  = 0;

    led_pattern_gen #(
        .CLK_HZ(CLK_HZ), .TICK_HZ(TICK_HZ), .N_CH(N_CH), .PER_W(PER_W), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .rst(rst), .cfg_valid(cfgValid), .cfg_ready(cfgReady),
        .cfg_ch(cfgCh[1:0]), .cfg_mode(cfgMode), .cfg_period(cfgPeriod),
        .cfg_high(cfgHigh), .cfg_count(cfgCount), .led(led), .done(done)
    );

    led_pattern_gen #(
        .CLK_HZ(CLK_HZ), .TICK_HZ(TICK_HZ), .N_CH(5), .PER_W(PER_W), .CNT_W(CNT_W)
    ) dut2 (
        .clk(clk), .rst(rst), .cfg_valid(cfgValid2), .cfg_ready(cfgReady2),
        .cfg_ch(cfgCh), .cfg_mode(cfgMode), .cfg_period(cfgPeriod),
        .cfg_high(cfgHigh), .cfg_count(cfgCount), .led(led2), .done(done2)
    );

    // Free-running 10 ns clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mkIdle(string name);
        vec_t v;
        v.name = name; v.rst = 1'b0; v.valid = 1'b0; v.valid2 = 1'b0;
        v.ch = '0; v.mode = '0; v.period = '0; v.high = '0; v.count = '0;
        v.expLed = '0; v.expDone = '0; v.expReady = 1'b0; v.readyCare = 1'b0;
        v.expLed2 = '0; v.expReady2 = 1'b0; v.dut2Care = 1'b0;
        return v;
    endfunction

    function automatic vec_t mkCfg(string name, bit toDut2, logic [2:0] ch, logic [1:0] mode,
                                   int period, int high, int count);
        vec_t v = mkIdle(name);
        v.valid  = !toDut2;
        v.valid2 = toDut2;
        v.ch     = ch;
        v.mode   = mode;
        v.period = PER_W'(period);
        v.high   = PER_W'(high);
        v.count  = CNT_W'(count);
        return v;
    endfunction

    // ready < 0 means cfg_ready is not checked for this cycle.
    function automatic vec_t withExp(vec_t vin, logic [3:0] ledV, logic [3:0] doneV, int ready);
        vec_t v = vin;
        v.expLed    = ledV;
        v.expDone   = doneV;
        v.readyCare = (ready >= 0);
        v.expReady  = (ready == 1);
        return v;
    endfunction

    function automatic vec_t withExp2(vec_t vin, logic [4:0] led2V, logic ready2V);
        vec_t v = vin;
        v.expLed2   = led2V;
        v.expReady2 = ready2V;
        v.dut2Care  = 1'b1;
        return v;
    endfunction

    // Pattern window helper: true when edge e falls in one of the first
    // onSlots 10-clock slots of a perSlots-slot cycle starting at edge start.
    function automatic logic slotOn(int e, int start, int onSlots, int perSlots);
        return (((e - start) / 10) % perSlots) < onSlots;
    endfunction

    task automatic applyStimulus(input vec_t v);
        @(negedge clk);
        rst       = v.rst;
        cfgValid  = v.valid;
        cfgValid2 = v.valid2;
        cfgCh     = v.ch;
        cfgMode   = v.mode;
        cfgPeriod = v.period;
        cfgHigh   = v.high;
        cfgCount  = v.count;
        sb.push_back(v);
        @(posedge clk);
    endtask

    task automatic checkOutput(input vec_t v);
        nChecks++;
        if (led !== v.expLed) begin
            nFails++;
            $display("[TB] FAIL %s led: got %b, want %b", v.name, led, v.expLed);
        end
        nChecks++;
        if (done !== v.expDone) begin
            nFails++;
            $display("[TB] FAIL %s done: got %b, want %b", v.name, done, v.expDone);
        end
        if (v.readyCare) begin
            nChecks++;
            if (cfgReady !== v.expReady) begin
                nFails++;
                $display("[TB] FAIL %s cfg_ready: got %b, want %b", v.name, cfgReady, v.expReady);
            end
        end
        if (v.dut2Care) begin
            nChecks++;
            if (led2 !== v.expLed2 || done2 !== 5'b00000 || cfgReady2 !== v.expReady2) begin
                nFails++;
                $display("[TB] FAIL %s dut2: got led=%b done=%b ready=%b, want led=%b done=00000 ready=%b",
                         v.name, led2, done2, cfgReady2, v.expLed2, v.expReady2);
            end
        end
    endtask

    task automatic doReset();
        vec_t v;
        for (int i = 0; i < 3; i++) begin
            v = mkIdle("reset");
            v.rst = 1'b1;
            applyStimulus(withExp(v, 4'b0000, 4'b0000, 0));
        end
    endtask

    // Compare every queued expectation just after the edge it belongs to.
    always @(posedge clk) begin
        #1;
        if (sb.size() > 0) checkOutput(sb.pop_front());
    end

    // Hard time limit so the run always ends.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got no end of test, want end before time limit");
        $fatal(1, "[TB] time limit reached");
    end

    initial begin
        vec_t v;
        logic l;
        rst = 1'b1; cfgValid = 1'b0; cfgValid2 = 1'b0; cfgCh = '0; cfgMode = '0;
        cfgPeriod = '0; cfgHigh = '0; cfgCount = '0;

        // Reset values, ready one cycle after release, then ch0 BLINK 4/1
        // loaded on a tick edge: 10 clk on, 30 clk off.
        $display("[TB] reset and blink");
        doReset();
        for (int e = 1; e <= 9; e++)
            applyStimulus(withExp(mkIdle("idle_after_reset"), 4'b0000, 4'b0000, 1));
        applyStimulus(withExp(mkCfg("blink_cfg", 0, 3'd0, M_BLINK, 4, 1, 0), 4'b0000, 4'b0000, 0));
        for (int e = 11; e <= 70; e++) begin
            l = slotOn(e, 11, 1, 4);
            applyStimulus(withExp(mkIdle("blink_run"), {3'b000, l}, 4'b0000, 1));
        end

        // ch1 BURST 2/1 count 3: three 10-clk pulses then a done pulse.
        $display("[TB] burst");
        doReset();
        for (int e = 1; e <= 9; e++)
            applyStimulus(withExp(mkIdle("idle"), 4'b0000, 4'b0000, 1));
        applyStimulus(withExp(mkCfg("burst_cfg", 0, 3'd1, M_BURST, 2, 1, 3), 4'b0000, 4'b0000, 0));
        for (int e = 11; e <= 100; e++) begin
            l = (e <= 60) && slotOn(e, 11, 1, 2);
            applyStimulus(withExp(mkIdle("burst_run"), {2'b00, l, 1'b0},
                                  (e == 71) ? 4'b0010 : 4'b0000, 1));
        end

        // ch2 ON then OFF with valid held: second write lands 2 cycles later.
        $display("[TB] back-to-back config");
        doReset();
        for (int e = 1; e <= 9; e++)
            applyStimulus(withExp(mkIdle("idle"), 4'b0000, 4'b0000, 1));
        applyStimulus(withExp(mkCfg("b2b_on", 0, 3'd2, M_ON, 1, 1, 0), 4'b0000, 4'b0000, 0));
        applyStimulus(withExp(mkCfg("b2b_off_wait", 0, 3'd2, M_OFF, 1, 0, 0), 4'b0100, 4'b0000, 1));
        applyStimulus(withExp(mkCfg("b2b_off_acc", 0, 3'd2, M_OFF, 1, 0, 0), 4'b0100, 4'b0000, 0));
        for (int e = 13; e <= 20; e++)
            applyStimulus(withExp(mkIdle("b2b_after"), 4'b0000, 4'b0000, 1));

        // Edge cases as a vector table: high=0, high=period, period=0,
        // BURST with count 0, and an out-of-range channel on the 5-channel DUT.
        $display("[TB] edge case table");
        doReset();
        for (int e = 1; e <= 9; e++)
            tbl.push_back(withExp2(withExp(mkIdle("t5_idle"), 4'b0000, 4'b0000, 1), 5'b00000, 1'b1));
        tbl.push_back(withExp2(withExp(mkCfg("high0_cfg", 0, 3'd0, M_BLINK, 4, 0, 0), 4'b0000, 4'b0000, 0), 5'b00000, 1'b1));
        tbl.push_back(withExp2(withExp(mkIdle("t5_gap1"), 4'b0000, 4'b0000, 1), 5'b00000, 1'b1));
        tbl.push_back(withExp2(withExp(mkCfg("highP_cfg", 0, 3'd1, M_BLINK, 5, 5, 0), 4'b0000, 4'b0000, 0), 5'b00000, 1'b1));
        tbl.push_back(withExp2(withExp(mkIdle("t5_gap2"), 4'b0010, 4'b0000, 1), 5'b00000, 1'b1));
        tbl.push_back(withExp2(withExp(mkCfg("per0_cfg", 0, 3'd2, M_BLINK, 0, 1, 0), 4'b0010, 4'b0000, 0), 5'b00000, 1'b1));
        tbl.push_back(withExp2(withExp(mkIdle("t5_gap3"), 4'b0110, 4'b0000, 1), 5'b00000, 1'b1));
        tbl.push_back(withExp2(withExp(mkCfg("cnt0_cfg", 0, 3'd3, M_BURST, 1, 1, 0), 4'b0110, 4'b0000, 0), 5'b00000, 1'b1));
        tbl.push_back(withExp2(withExp(mkIdle("cnt0_done"), 4'b0110, 4'b1000, 1), 5'b00000, 1'b1));
        tbl.push_back(withExp2(withExp(mkCfg("dut2_ch0_on", 1, 3'd0, M_ON, 1, 1, 0), 4'b0110, 4'b0000, 1), 5'b00000, 1'b0));
        tbl.push_back(withExp2(withExp(mkIdle("t5_gap4"), 4'b0110, 4'b0000, 1), 5'b00001, 1'b1));
        tbl.push_back(withExp2(withExp(mkCfg("dut2_ch7", 1, 3'd7, M_ON, 1, 1, 0), 4'b0110, 4'b0000, 1), 5'b00001, 1'b0));
        for (int e = 21; e <= 60; e++)
            tbl.push_back(withExp2(withExp(mkIdle("t5_hold"), 4'b0110, 4'b0000, 1), 5'b00001, 1'b1));
        for (int i = 0; i < tbl.size(); i++)
            applyStimulus(tbl[i]);

        // Reset in the middle of a burst on ch3, with a config in flight.
        $display("[TB] reset mid-burst");
        doReset();
        for (int e = 1; e <= 9; e++)
            applyStimulus(withExp(mkIdle("idle"), 4'b0000, 4'b0000, 1));
        applyStimulus(withExp(mkCfg("rb_cfg", 0, 3'd3, M_BURST, 2, 1, 2), 4'b0000, 4'b0000, 0));
        for (int e = 11; e <= 14; e++)
            applyStimulus(withExp(mkIdle("rb_run"), 4'b1000, 4'b0000, 1));
        v = mkCfg("rb_reset", 0, 3'd0, M_ON, 1, 1, 0);
        v.rst = 1'b1;
        applyStimulus(withExp(v, 4'b0000, 4'b0000, 0));
        for (int e = 16; e <= 70; e++)
            applyStimulus(withExp(mkIdle("rb_after"), 4'b0000, 4'b0000, 1));

        // New ch3 config accepted on the wrap edge that would end the old
        // burst: new BLINK 4/2 runs, no done.
        $display("[TB] config on final wrap");
        doReset();
        for (int e = 1; e <= 9; e++)
            applyStimulus(withExp(mkIdle("idle"), 4'b0000, 4'b0000, 1));
        applyStimulus(withExp(mkCfg("cw_burst", 0, 3'd3, M_BURST, 2, 1, 1), 4'b0000, 4'b0000, 0));
        for (int e = 11; e <= 29; e++) begin
            l = (e <= 20);
            applyStimulus(withExp(mkIdle("cw_old"), {l, 3'b000}, 4'b0000, 1));
        end
        applyStimulus(withExp(mkCfg("cw_new", 0, 3'd3, M_BLINK, 4, 2, 0), 4'b0000, 4'b0000, 0));
        for (int e = 31; e <= 80; e++) begin
            l = slotOn(e, 31, 2, 4);
            applyStimulus(withExp(mkIdle("cw_new_run"), {l, 3'b000}, 4'b0000, 1));
        end

        #3;
        nChecks++;
        if (sb.size() != 0) begin
            nFails++;
            $display("[TB] FAIL scoreboard_drained: got %0d pending, want 0", sb.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
